rotate_square: RTL and testbench

ROTATE_SQUARE -- requirements
Module: rotate_square

---
 rtl/rotate_square_pkg.sv | 16 +
 rtl/rotate_square_tick_gen.sv | 35 +++
 rtl/rotate_square.sv | 53 +++++
 tb/tb_rotate_square.sv | 126 ++++++++++++
 4 files changed

// File: rtl/rotate_square_pkg.sv
// Shared constants and types for the rotating-square display.
// Segment patterns are ordered {g,f,e,d,c,b,a} and are active-low.
package rotate_square_pkg;

    localparam logic [6:0] SQ_UPPER = 7'b0011100;
    localparam logic [6:0] SQ_LOWER = 7'b0100011;

    typedef logic [2:0] pos_t;

    // Digit index (3 = leftmost) showing the square for a given position.
    // The upper half runs right-to-left in index, the lower half left-to-right.
    function automatic logic [1:0] digit_of(input pos_t p);
        return p[2] ? p[1:0] : ~p[1:0];
    endfunction

endpackage

// File: rtl/rotate_square_tick_gen.sv
// Free-running N-bit prescaler; pulses tick on the last count while enabled.
// The count freezes whenever en is low and resumes from the held value.
module tick_gen #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    logic [N-1:0] cnt_reg;
    logic [N-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = en && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/rotate_square.sv
// Rotating square on a 4-digit 7-segment display: the square walks across the
// upper half of the digits, then back along the lower half, once per prescaler tick.
module rotate_square
    import rotate_square_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] sseg
);

    logic tick;
    pos_t pos_reg;
    pos_t pos_next;
    logic [1:0] digit;

    tick_gen #(
        .N(N)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Direction is only looked at on the tick cycle itself.
    always_comb begin
        pos_next = pos_reg;
        if (tick) begin
            pos_next = up ? pos_reg + 3'd1 : pos_reg - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_reg <= '0;
        end else begin
            pos_reg <= pos_next;
        end
    end

    assign digit = digit_of(pos_reg);
    assign sseg  = pos_reg[2] ? SQ_LOWER : SQ_UPPER;

    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign an[gi] = (digit != 2'(gi));
    end

endmodule

// File: tb/tb_rotate_square.sv
// Directed bench for rotate_square (N=4): vector table plus reset/cnt sequences.
module tb_rotate_square;

    localparam logic [6:0] UPS = 7'b0011100;
    localparam logic [6:0] LOS = 7'b0100011;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        int         ncyc;
        logic [3:0] an;
        logic [6:0] sseg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up  = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] an;
    logic [6:0] sseg;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[21];

    rotate_square #(
        .N(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .up   (up),
        .en   (en),
        .an   (an),
        .sseg (sseg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks, sampling 1 ns after each edge and checking one-hot-low an.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check("an_onehot_low", 32'($countones(~an) == 1), 32'd1);
        end
    endtask

    initial begin
        // rst en up ncyc an sseg (state after the row)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1,  4'b0111, UPS}; // reset -> pos0
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 15, 4'b0111, UPS}; // cnt15, no step yet
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1,  4'b1011, UPS}; // 16th clock -> pos1
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16, 4'b1101, UPS}; // pos2
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16, 4'b1110, UPS}; // pos3
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16, 4'b1110, LOS}; // pos4
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 5,  4'b1110, LOS}; // pos4 cnt5
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 10, 4'b1110, LOS}; // paused
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 10, 4'b1110, LOS}; // cnt15
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1,  4'b1101, LOS}; // pos5
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16, 4'b1011, LOS}; // pos6
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16, 4'b0111, LOS}; // pos7
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16, 4'b0111, UPS}; // cw wrap -> pos0
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16, 4'b0111, LOS}; // ccw wrap -> pos7
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16, 4'b1011, LOS}; // pos6
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8,  4'b1011, LOS}; // up=0 mid-count
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8,  4'b0111, LOS}; // up=1 at tick -> pos7
        vecs[17] = '{1'b0, 1'b1, 1'b0, 15, 4'b0111, LOS}; // up=0 between ticks
        vecs[18] = '{1'b0, 1'b1, 1'b1, 1,  4'b0111, UPS}; // up=1 at tick -> pos0
        vecs[19] = '{1'b0, 1'b1, 1'b1, 80, 4'b1101, LOS}; // pos5
        vecs[20] = '{1'b0, 1'b1, 1'b1, 9,  4'b1101, LOS}; // pos5 cnt9

        for (int i = 0; i < 21; i++) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            up  = vecs[i].up;
            step(vecs[i].ncyc);
            check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
            check($sformatf("vec%0d_sseg", i), 32'(sseg), 32'(vecs[i].sseg));
        end

        // Reset mid-operation at pos5, cnt9, with en and up still asserted.
        check("cnt_before_rst", 32'(dut.u_tick.cnt_reg), 32'd9);
        rst = 1'b1;
        step(1);
        check("rst_mid_an", 32'(an), 32'(4'b0111));
        check("rst_mid_sseg", 32'(sseg), 32'(UPS));
        check("rst_mid_cnt", 32'(dut.u_tick.cnt_reg), 32'd0);
        step(2);
        check("rst_hold_an", 32'(an), 32'(4'b0111));
        check("rst_hold_cnt", 32'(dut.u_tick.cnt_reg), 32'd0);
        rst = 1'b0;
        step(15);
        check("post_rst_15_an", 32'(an), 32'(4'b0111));
        check("post_rst_15_cnt", 32'(dut.u_tick.cnt_reg), 32'd15);
        step(1);
        check("post_rst_16_an", 32'(an), 32'(4'b1011));
        check("post_rst_16_sseg", 32'(sseg), 32'(UPS));

        // Pause holds cnt exactly.
        step(3);
        en = 1'b0;
        step(10);
        check("pause_cnt", 32'(dut.u_tick.cnt_reg), 32'd3);
        check("pause_an", 32'(an), 32'(4'b1011));
        en = 1'b1;
        step(12);
        check("resume_pre_an", 32'(an), 32'(4'b1011));
        step(1);
        check("resume_step_an", 32'(an), 32'(4'b1101));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
